pc_sequencer: RTL and testbench

Run-control sequencer for the single-cycle datapath (`SCDataPath`). It owns the datapath's `PC` input and feeds back the datapath's next-PC output (`PCCurrent`) once per cycle. It adds start, pause, single-step, breakpoint and retired-instruction-limit control, so benches and the debug path can sequence the datapath without hand-driving `PC`.

---
 rtl/pc_sequencer.sv | 88 ++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: run-control FSM that owns the datapath PC and adds start,
// pause, single-step, breakpoint and retired-instruction-limit control.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      start_pc,
  input  logic             pause_req,
  input  logic             resume,
  input  logic             step,
  input  logic             bp_enable,
  input  logic [31:0]      bp_addr,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [31:0]      next_pc,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } state_t;
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d, retired_inc;
  logic [1:0]       cause_q, cause_d;
  logic             limit_hit, bp_hit;
  assign pc_valid    = state_q == RUN || state_q == STEP;
  assign halted      = state_q == DONE;
  assign retired_inc = retired_q + 1'b1;
  assign limit_hit   = cycle_limit != '0 && retired_inc == cycle_limit;
  // next_pc is the instruction about to run, so a hit stops before it executes
  assign bp_hit      = bp_enable && next_pc == bp_addr;
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign state       = state_q;
  assign halt_cause  = cause_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    if (pc_valid) begin
      pc_d      = next_pc;
      retired_d = &retired_q ? retired_q : retired_inc;
    end
    case (state_q)
      IDLE, DONE: if (start) begin
        pc_d      = start_pc;
        retired_d = '0;
        cause_d   = 2'd0;
        state_d   = RUN;
      end
      RUN: begin
        state_d = limit_hit || bp_hit || pause_req ? (limit_hit ? DONE : PAUSE) : RUN;
        cause_d = limit_hit ? 2'd3 : bp_hit ? 2'd1 : pause_req ? 2'd2 : cause_q;
      end
      PAUSE: state_d = resume ? RUN : step ? STEP : PAUSE;
      STEP: begin
        state_d = limit_hit ? DONE : PAUSE;
        cause_d = limit_hit ? 2'd3 : cause_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench with a PC+4 stub datapath and a
// cycle-level reference model compared on every falling edge.
module tb_pc_sequencer;
  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [31:0] start_pc = 0;
  logic        pause_req = 0;
  logic        resume = 0;
  logic        step = 0;
  logic        bp_enable = 0;
  logic [31:0] bp_addr = 0;
  logic [15:0] cycle_limit = 0;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        pc_valid;
  logic [15:0] retired;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  halt_cause;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign next_pc = pc + 32'd4;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .start_pc(start_pc),
    .pause_req(pause_req), .resume(resume), .step(step),
    .bp_enable(bp_enable), .bp_addr(bp_addr), .cycle_limit(cycle_limit),
    .next_pc(next_pc), .pc(pc), .pc_valid(pc_valid), .retired(retired),
    .state(state), .halted(halted), .halt_cause(halt_cause)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  // Reference model: named modes, plain integer arithmetic for PC and count
  int          m_mode;
  logic [31:0] m_pc;
  int          m_ret;
  int          m_cause;
  bit          armed = 0;
  bit          running, lim;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_pc = 0; m_ret = 0; m_cause = 0; armed = 1;
    end else if (m_mode == 0 || m_mode == 4) begin
      if (start) begin
        m_mode = 1; m_pc = start_pc; m_ret = 0; m_cause = 0;
      end
    end else if (m_mode == 2) begin
      if (resume) m_mode = 1;
      else if (step) m_mode = 3;
    end else begin
      running = (m_mode == 1);
      lim = (cycle_limit != 0) && (m_ret + 1 == int'(cycle_limit));
      m_pc = m_pc + 4;
      m_ret = (m_ret == 65535) ? 65535 : m_ret + 1;
      if (lim) begin m_mode = 4; m_cause = 3; end
      else if (!running) m_mode = 2;
      else if (bp_enable && m_pc == bp_addr) begin m_mode = 2; m_cause = 1; end
      else if (pause_req) begin m_mode = 2; m_cause = 2; end
    end
  end

  always @(negedge clock) if (armed) begin
    chk("model_state", state, m_mode);
    chk("model_pc", pc, m_pc);
    chk("model_retired", retired, m_ret);
    chk("model_cause", halt_cause, m_cause);
    chk("model_pc_valid", pc_valid, (m_mode == 1 || m_mode == 3));
    chk("model_halted", halted, (m_mode == 4));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic do_start(input logic [31:0] a);
    start_pc = a; start = 1; tick(); start = 0;
  endtask

  int vcnt;

  initial begin
    tick(2);
    reset = 0;
    chk("rst_pc", pc, 0);
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_pc_valid", pc_valid, 0);
    chk("rst_halted", halted, 0);

    do_start(12);
    for (int i = 0; i < 5; i++) begin
      chk("run_pc", pc, 12 + 4 * i);
      tick();
    end
    chk("run_pc_end", pc, 32);
    chk("run_retired", retired, 5);
    pause_req = 1; tick(); pause_req = 0;
    chk("pause_state", state, 2);
    chk("pause_pc", pc, 36);
    chk("pause_cause", halt_cause, 2);

    do_reset();
    bp_enable = 1; bp_addr = 28;
    do_start(12);
    for (int i = 0; i < 10 && state != 3'd2; i++) tick();
    chk("bp_state", state, 2);
    chk("bp_pc", pc, 28);
    chk("bp_retired", retired, 4);
    chk("bp_cause", halt_cause, 1);
    step = 1; tick(); step = 0;
    vcnt = pc_valid;
    chk("step1_pc", pc, 28);
    tick(); vcnt += pc_valid;
    chk("step1_after", pc, 32);
    tick(); vcnt += pc_valid;
    step = 1; tick(); step = 0;
    vcnt += pc_valid;
    tick(); vcnt += pc_valid;
    tick(); vcnt += pc_valid;
    chk("step_valid_count", vcnt, 2);
    chk("step2_pc", pc, 36);
    chk("step_retired", retired, 6);
    chk("step_cause_kept", halt_cause, 1);
    step = 1; resume = 1; tick(); step = 0; resume = 0;
    chk("step_resume_run", state, 1);
    tick(2);

    do_reset();
    do_start(12);
    for (int i = 0; i < 10 && state != 3'd2; i++) tick();
    resume = 1; tick(); resume = 0;
    chk("resume_pc0", pc, 28);
    tick();
    chk("resume_pc1", pc, 32);
    tick();
    chk("resume_pc2", pc, 36);
    chk("resume_state", state, 1);
    bp_enable = 0;

    do_reset();
    cycle_limit = 3;
    do_start(20);
    tick(3);
    chk("lim_state", state, 4);
    chk("lim_pc", pc, 32);
    chk("lim_retired", retired, 3);
    chk("lim_halted", halted, 1);
    chk("lim_cause", halt_cause, 3);
    tick();
    chk("lim_hold_pc", pc, 32);
    do_start(0);
    chk("restart_pc", pc, 0);
    chk("restart_retired", retired, 0);
    chk("restart_state", state, 1);
    tick(4);

    do_reset();
    cycle_limit = 0;
    do_start(12);
    tick(3);
    chk("mid_pc_pre", pc, 24);
    reset = 1; start = 1; start_pc = 100; tick(); reset = 0; start = 0;
    chk("mid_state", state, 0);
    chk("mid_pc", pc, 0);
    chk("mid_retired", retired, 0);
    tick();
    chk("mid_idle_hold", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
